// File: rtl/redmule_pkg.sv
// Shared types for the RedMulE tile sequencer: FSM state encoding and default counter width.
package redmule_pkg;

   localparam int unsigned CntWidthDef = 16;

   typedef enum logic [2:0] {
      SEQ_IDLE,
      SEQ_LOAD_X,
      SEQ_LOAD_W,
      SEQ_START,
      SEQ_COMPUTE,
      SEQ_STORE_Z,
      SEQ_DONE
   } redmule_seq_state_e;

endpackage

// File: rtl/redmule_tile_counter.sv
// One tile-loop counter: latches its tile count at job start and tracks the current index.
module redmule_tile_counter
   import redmule_pkg::*;
#(
   parameter int unsigned CntWidth = CntWidthDef
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                clear_i,
   input  logic                load_i,
   input  logic [CntWidth-1:0] count_i,
   input  logic                incr_i,
   input  logic                rst_idx_i,
   output logic [CntWidth-1:0] idx_o,
   output logic                last_o
);

   logic [CntWidth-1:0] count_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
         idx_o   <= '0;
      end else if (clear_i) begin
         count_q <= '0;
         idx_o   <= '0;
      end else if (load_i) begin
         count_q <= count_i;
         idx_o   <= '0;
      end else if (rst_idx_i) begin
         idx_o <= '0;
      end else if (incr_i) begin
         idx_o <= idx_o + CntWidth'(1);
      end
   end

   // Compare against count-1 so an all-ones count never needs the index to wrap.
   assign last_o = (idx_o == count_q - CntWidth'(1));

endmodule

// File: rtl/redmule_tile_sequencer.sv
// Walks a tiled GEMM job (m outer, n middle, k inner), issuing X/W loads, engine
// compute pulses and one Z store per (m,n) through req/gnt handshakes.
module redmule_tile_sequencer
   import redmule_pkg::*;
#(
   parameter int unsigned CntWidth = CntWidthDef
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                clear_i,
   input  logic                start_i,
   input  logic [CntWidth-1:0] m_tiles_i,
   input  logic [CntWidth-1:0] n_tiles_i,
   input  logic [CntWidth-1:0] k_tiles_i,
   output logic                x_req_o,
   input  logic                x_gnt_i,
   output logic                w_req_o,
   input  logic                w_gnt_i,
   output logic                eng_start_o,
   input  logic                eng_done_i,
   output logic                z_req_o,
   input  logic                z_gnt_i,
   output logic [CntWidth-1:0] m_idx_o,
   output logic [CntWidth-1:0] n_idx_o,
   output logic [CntWidth-1:0] k_idx_o,
   output logic                busy_o,
   output logic                done_o
);

   redmule_seq_state_e state_q;

   logic load;
   logic zero_cnt;
   logic m_incr, m_rst, m_last;
   logic n_incr, n_rst, n_last;
   logic k_incr, k_rst, k_last;

   // Counter controls: indices move only on completed handshakes and at DONE.
   always_comb begin
      load     = 1'b0;
      zero_cnt = (m_tiles_i == '0) || (n_tiles_i == '0) || (k_tiles_i == '0);
      m_incr   = 1'b0;
      m_rst    = 1'b0;
      n_incr   = 1'b0;
      n_rst    = 1'b0;
      k_incr   = 1'b0;
      k_rst    = 1'b0;
      case (state_q)
         SEQ_IDLE: load = start_i;
         SEQ_COMPUTE: begin
            if (eng_done_i) begin
               k_incr = !k_last;
               k_rst  = k_last;
            end
         end
         SEQ_STORE_Z: begin
            if (z_gnt_i) begin
               n_incr = !n_last;
               n_rst  = n_last && !m_last;
               m_incr = n_last && !m_last;
            end
         end
         SEQ_DONE: begin
            m_rst = 1'b1;
            n_rst = 1'b1;
            k_rst = 1'b1;
         end
         default: ;
      endcase
   end

   redmule_tile_counter #(.CntWidth(CntWidth)) i_m_cnt (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .clear_i  (clear_i),
      .load_i   (load),
      .count_i  (m_tiles_i),
      .incr_i   (m_incr),
      .rst_idx_i(m_rst),
      .idx_o    (m_idx_o),
      .last_o   (m_last)
   );

   redmule_tile_counter #(.CntWidth(CntWidth)) i_n_cnt (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .clear_i  (clear_i),
      .load_i   (load),
      .count_i  (n_tiles_i),
      .incr_i   (n_incr),
      .rst_idx_i(n_rst),
      .idx_o    (n_idx_o),
      .last_o   (n_last)
   );

   redmule_tile_counter #(.CntWidth(CntWidth)) i_k_cnt (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .clear_i  (clear_i),
      .load_i   (load),
      .count_i  (k_tiles_i),
      .incr_i   (k_incr),
      .rst_idx_i(k_rst),
      .idx_o    (k_idx_o),
      .last_o   (k_last)
   );

   // State and registered outputs; each req is set on entry to its state and cleared on its gnt.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= SEQ_IDLE;
         x_req_o     <= 1'b0;
         w_req_o     <= 1'b0;
         z_req_o     <= 1'b0;
         eng_start_o <= 1'b0;
         busy_o      <= 1'b0;
         done_o      <= 1'b0;
      end else if (clear_i) begin
         state_q     <= SEQ_IDLE;
         x_req_o     <= 1'b0;
         w_req_o     <= 1'b0;
         z_req_o     <= 1'b0;
         eng_start_o <= 1'b0;
         busy_o      <= 1'b0;
         done_o      <= 1'b0;
      end else begin
         eng_start_o <= 1'b0;
         done_o      <= 1'b0;
         case (state_q)
            SEQ_IDLE: begin
               if (start_i) begin
                  busy_o <= 1'b1;
                  if (zero_cnt) begin
                     state_q <= SEQ_DONE;
                  end else begin
                     state_q <= SEQ_LOAD_X;
                     x_req_o <= 1'b1;
                  end
               end
            end
            SEQ_LOAD_X: begin
               if (x_gnt_i) begin
                  state_q <= SEQ_LOAD_W;
                  x_req_o <= 1'b0;
                  w_req_o <= 1'b1;
               end
            end
            SEQ_LOAD_W: begin
               if (w_gnt_i) begin
                  state_q     <= SEQ_START;
                  w_req_o     <= 1'b0;
                  eng_start_o <= 1'b1;
               end
            end
            SEQ_START: state_q <= SEQ_COMPUTE;
            SEQ_COMPUTE: begin
               if (eng_done_i) begin
                  if (k_last) begin
                     state_q <= SEQ_STORE_Z;
                     z_req_o <= 1'b1;
                  end else begin
                     state_q <= SEQ_LOAD_X;
                     x_req_o <= 1'b1;
                  end
               end
            end
            SEQ_STORE_Z: begin
               if (z_gnt_i) begin
                  z_req_o <= 1'b0;
                  if (n_last && m_last) begin
                     state_q <= SEQ_DONE;
                  end else begin
                     state_q <= SEQ_LOAD_X;
                     x_req_o <= 1'b1;
                  end
               end
            end
            SEQ_DONE: begin
               state_q <= SEQ_IDLE;
               busy_o  <= 1'b0;
               done_o  <= 1'b1;
            end
            default: state_q <= SEQ_IDLE;
         endcase
      end
   end

endmodule
